// File: rtl/cmult_pipe.sv
// Pipelined signed fixed-point complex multiplier, C = A*B or A*conj(B).
// Three stages (products, rounded sums, shift + range check) behind a
// valid/ready handshake; all stages stall together when the output is held.
// Build option: define CMULT_SAT_EN to clamp out-of-range components;
// otherwise they wrap to the low W bits. ovf is flagged in both builds.
module cmult_pipe #(
  parameter int W    = 16,
  parameter int FRAC = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           conj_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] c,
  output logic           ovf
);

  localparam logic signed [2*W:0] RND = {{(2*W){1'b0}}, 1'b1} << (FRAC-1);

  // True when the rounded, shifted sum does not fit in W signed bits.
  function automatic logic range_ovf(input logic signed [2*W:0] x);
    range_ovf = !((&x[2*W:W-1]) || !(|x[2*W:W-1]));
  endfunction

  // Reduce the shifted sum to a W-bit component: clamp or wrap.
  function automatic logic [W-1:0] reduce(input logic signed [2*W:0] x);
`ifdef CMULT_SAT_EN
    if (range_ovf(x))
      reduce = x[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      reduce = x[W-1:0];
`else
    reduce = x[W-1:0];
`endif
  endfunction

  logic                  w_en;
  logic signed [W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [2*W-1:0] w_rr, w_ii, w_ri, w_ir;

  logic                  r_vld_p1, r_conj_p1;
  logic signed [2*W-1:0] r_rr_p1, r_ii_p1, r_ri_p1, r_ir_p1;
  logic signed [2*W:0]   w_rr_x, w_ii_x, w_ri_x, w_ir_x;
  logic signed [2*W:0]   w_re_sum, w_im_sum;

  logic                  r_vld_p2;
  logic signed [2*W:0]   r_re_p2, r_im_p2;
  logic signed [2*W:0]   w_re_sh, w_im_sh;

  logic                  r_vld_p3, r_ovf_p3;
  logic [2*W-1:0]        r_c_p3;

  assign w_en      = !r_vld_p3 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_p3;
  assign c         = r_c_p3;
  assign ovf       = r_ovf_p3;

  assign w_a_re = a[2*W-1:W];
  assign w_a_im = a[W-1:0];
  assign w_b_re = b[2*W-1:W];
  assign w_b_im = b[W-1:0];

  assign w_rr = w_a_re * w_b_re;
  assign w_ii = w_a_im * w_b_im;
  assign w_ri = w_a_re * w_b_im;
  assign w_ir = w_a_im * w_b_re;

  // Stage 1: partial products, conj select and valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_conj_p1 <= 1'b0;
      r_rr_p1   <= '0;
      r_ii_p1   <= '0;
      r_ri_p1   <= '0;
      r_ir_p1   <= '0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_conj_p1 <= conj_b;
      r_rr_p1   <= w_rr;
      r_ii_p1   <= w_ii;
      r_ri_p1   <= w_ri;
      r_ir_p1   <= w_ir;
    end
  end

  assign w_rr_x = {r_rr_p1[2*W-1], r_rr_p1};
  assign w_ii_x = {r_ii_p1[2*W-1], r_ii_p1};
  assign w_ri_x = {r_ri_p1[2*W-1], r_ri_p1};
  assign w_ir_x = {r_ir_p1[2*W-1], r_ir_p1};

  assign w_re_sum = (r_conj_p1 ? (w_rr_x + w_ii_x) : (w_rr_x - w_ii_x)) + RND;
  assign w_im_sum = (r_conj_p1 ? (w_ir_x - w_ri_x) : (w_ri_x + w_ir_x)) + RND;

  // Stage 2: real/imag sums with the rounding constant folded in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p2 <= 1'b0;
      r_re_p2  <= '0;
      r_im_p2  <= '0;
    end else if (w_en) begin
      r_vld_p2 <= r_vld_p1;
      r_re_p2  <= w_re_sum;
      r_im_p2  <= w_im_sum;
    end
  end

  assign w_re_sh = r_re_p2 >>> FRAC;
  assign w_im_sh = r_im_p2 >>> FRAC;

  // Stage 3: shifted result, overflow flag and output valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p3 <= 1'b0;
      r_ovf_p3 <= 1'b0;
      r_c_p3   <= '0;
    end else if (w_en) begin
      r_vld_p3 <= r_vld_p2;
      r_ovf_p3 <= range_ovf(w_re_sh) || range_ovf(w_im_sh);
      r_c_p3   <= {reduce(w_re_sh), reduce(w_im_sh)};
    end
  end

endmodule

// File: tb/tb_cmult_pipe.sv
// Scoreboard bench for cmult_pipe (W=16, FRAC=15): driver pushes expected
// results on input accept, monitor pops and compares on output transfer.
module tb_cmult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        conj_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        ovf;

  typedef struct {
    logic [31:0] c;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  cmult_pipe #(.W(16), .FRAC(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .conj_b(conj_b), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one sample, wait (bounded) for in_ready, record expectation.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                      input logic [31:0] ec, input logic eo);
    int   n;
    exp_t e;
    a = ta; b = tb_v; conj_b = tc; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "input stalled");
      end
    end
    e.c = ec; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges from the accepting edge until out_valid is seen.
  task automatic measure_lat(input string nm);
    int lat;
    lat = 1;
    while (lat < 10) begin
      @(posedge clk); lat++; #1;
      if (out_valid) break;
    end
    chk(nm, lat, 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", c, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("c", c, e.c);
          chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
          n_out++;
        end
      end
    end
  end

  logic [31:0] stream_a [8] = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000,
                                32'h0500_0000, 32'h0600_0000, 32'h0700_0000, 32'h0800_0000};
  logic [31:0] stream_c [8] = '{32'h0080_0000, 32'h0100_0000, 32'h0180_0000, 32'h0200_0000,
                                32'h0280_0000, 32'h0300_0000, 32'h0380_0000, 32'h0400_0000};

  initial begin
    logic [31:0] ovf_c;
    int          base;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; conj_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_c", c, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic product and latency.
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h2000_0000, 1'b0);
    measure_lat("latency_basic");
    drain();

    // j*j, conj, rounding, overflow.
    send(32'h0000_4000, 32'h0000_4000, 1'b0, 32'hE000_0000, 1'b0);
    send(32'h4000_4000, 32'h4000_4000, 1'b1, 32'h4000_0000, 1'b0);
    send(32'h4000_4000, 32'h4000_4000, 1'b0, 32'h0000_4000, 1'b0);
    send(32'h0001_0000, 32'h4000_0000, 1'b0, 32'h0001_0000, 1'b0);
    send(32'hFFFF_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b0);
`ifdef CMULT_SAT_EN
    ovf_c = 32'h7FFF_0000;
`else
    ovf_c = 32'h8000_0000;
`endif
    send(32'h8000_0000, 32'h8000_0000, 1'b0, ovf_c, 1'b1);
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h2000_0000, 1'b0);
    drain();

    // Backpressure: 8 back-to-back, out_ready low for 5 clk after 2nd output.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(stream_a[i], 32'h4000_0000, 1'b0, stream_c[i], 1'b0);
      end
      begin
        logic [31:0] held;
        int          n;
        n = 0;
        while (n_out < base + 2 && n < 100) begin
          @(posedge clk); #1; n++;
        end
        chk("bp_second_output", n_out - base, 2);
        out_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
          chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
          if (k == 0) held = c;
          else chk("bp_c_stable", c, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - base, 8);

    // Reset with three samples in flight.
    send(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h2000_0000, 1'b0);
    send(32'h4000_4000, 32'h4000_4000, 1'b1, 32'h4000_0000, 1'b0);
    send(32'h0000_4000, 32'h0000_4000, 1'b0, 32'hE000_0000, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_c", c, 32'd0);
    chk("midrst_ovf", {31'b0, ovf}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(32'h0001_0000, 32'h4000_0000, 1'b0, 32'h0001_0000, 1'b0);
    measure_lat("latency_after_reset");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
